// File: rtl/dlsc_pcie_s6_outbound_write_tlp_pkg.sv
// Shared TLP constants, FSM states and header-field helpers for the Spartan-6
// outbound write TLP builder.
package dlsc_pcie_s6_outbound_write_tlp_pkg;

  localparam logic [1:0] FMT_3DW_D = 2'b10;
  localparam logic [1:0] FMT_4DW_D = 2'b11;
  localparam logic [4:0] TYPE_MEM  = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1,
    ST_H2,
    ST_H3,
    ST_DATA
  } state_t;

  // MWr DW0: TC=0, TD=0, EP=0, attr=0
  function automatic logic [31:0] mwr_dw0(input logic [1:0] fmt, input logic [9:0] len);
    return {1'b0, fmt, TYPE_MEM, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
  endfunction

  function automatic logic [31:0] mwr_dw1(input logic [7:0] bus, input logic [4:0] dev,
                                          input logic [2:0] func, input logic [3:0] be_last,
                                          input logic [3:0] be_first);
    return {bus, dev, func, 8'h00, be_last, be_first};
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_write_tlp.sv
// Builds 3DW/4DW Memory Write TLPs onto the Spartan-6 32-bit TRN TX port.
// Optional DLSC_PCIE_S6_TX_BUF_CHECK_EN: hold off new frames while trn_tbuf_av==0.
module dlsc_pcie_s6_outbound_write_tlp
  import dlsc_pcie_s6_outbound_write_tlp_pkg::*;
#(
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      cfg_bus_number,
  input  logic [4:0]      cfg_device_number,
  input  logic [2:0]      cfg_function_number,
  output logic            tlp_h_ready,
  input  logic            tlp_h_valid,
  input  logic [ADDR-3:0] tlp_h_addr,
  input  logic [9:0]      tlp_h_len,
  input  logic [3:0]      tlp_h_be_first,
  input  logic [3:0]      tlp_h_be_last,
  output logic            tlp_d_ready,
  input  logic            tlp_d_valid,
  input  logic [31:0]     tlp_d_data,
  input  logic            trn_tdst_rdy_n,
  input  logic [5:0]      trn_tbuf_av,
  output logic [31:0]     trn_td,
  output logic            trn_tsof_n,
  output logic            trn_teof_n,
  output logic            trn_tsrc_rdy_n,
  output logic            trn_tsrc_dsc_n,
  output logic            trn_terrfwd_n,
  output logic            trn_tstr_n
);

  state_t      state;
  logic        ready_en;
  logic        load_en;
  logic        buf_ok;
  logic        is_4dw;
  logic [31:0] addr_lo;
  logic [31:0] addr_hi;
  logic [31:0] hdr_dw1;
  logic [31:0] hdr_dw2;
  logic [31:0] hdr_dw3;
  logic        hdr_4dw;
  logic [10:0] remaining;

  assign trn_tsrc_dsc_n = 1'b1;
  assign trn_terrfwd_n  = 1'b1;
  assign trn_tstr_n     = 1'b1;

`ifdef DLSC_PCIE_S6_TX_BUF_CHECK_EN
  assign buf_ok = |trn_tbuf_av;
`else
  logic unused_tbuf_av;
  assign unused_tbuf_av = ^trn_tbuf_av;
  assign buf_ok = 1'b1;
`endif

  assign load_en = trn_tsrc_rdy_n | ~trn_tdst_rdy_n;
  assign addr_lo = {tlp_h_addr[29:0], 2'b00};

  // A 64-bit address whose upper half is zero must still go out as 3DW
  generate
    if (ADDR > 32) begin : g_addr64
      logic [ADDR-33:0] upper;
      assign upper   = tlp_h_addr[ADDR-3:30];
      assign addr_hi = 32'(upper);
      assign is_4dw  = |upper;
    end else begin : g_addr32
      assign addr_hi = '0;
      assign is_4dw  = 1'b0;
    end
  endgenerate

  assign tlp_h_ready = ready_en && (state == ST_IDLE) && load_en && buf_ok;
  assign tlp_d_ready = (state == ST_DATA) && load_en;

  // DW0 is loaded straight into the output register on header accept, so the
  // H0 step coincides with IDLE and back-to-back frames need no idle beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ready_en       <= 1'b0;
      trn_td         <= '0;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
      hdr_dw1        <= '0;
      hdr_dw2        <= '0;
      hdr_dw3        <= '0;
      hdr_4dw        <= 1'b0;
      remaining      <= '0;
    end else begin
      ready_en <= 1'b1;
      if (load_en) begin
        trn_tsof_n     <= 1'b1;
        trn_teof_n     <= 1'b1;
        trn_tsrc_rdy_n <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (tlp_h_ready && tlp_h_valid) begin
              trn_td     <= mwr_dw0(is_4dw ? FMT_4DW_D : FMT_3DW_D, tlp_h_len);
              trn_tsof_n <= 1'b0;
              hdr_dw1    <= mwr_dw1(cfg_bus_number, cfg_device_number, cfg_function_number,
                                    tlp_h_be_last, tlp_h_be_first);
              hdr_dw2    <= is_4dw ? addr_hi : addr_lo;
              hdr_dw3    <= addr_lo;
              hdr_4dw    <= is_4dw;
              remaining  <= (tlp_h_len == 10'd0) ? 11'd1024 : {1'b0, tlp_h_len};
              state      <= ST_H1;
            end else begin
              trn_tsrc_rdy_n <= 1'b1;
            end
          end
          ST_H1: begin
            trn_td <= hdr_dw1;
            state  <= ST_H2;
          end
          ST_H2: begin
            trn_td <= hdr_dw2;
            state  <= hdr_4dw ? ST_H3 : ST_DATA;
          end
          ST_H3: begin
            trn_td <= hdr_dw3;
            state  <= ST_DATA;
          end
          ST_DATA: begin
            if (tlp_d_valid) begin
              trn_td    <= tlp_d_data;
              remaining <= remaining - 11'd1;
              if (remaining == 11'd1) begin
                trn_teof_n <= 1'b0;
                state      <= ST_IDLE;
              end
            end else begin
              trn_tsrc_rdy_n <= 1'b1;
            end
          end
          default: begin
            trn_tsrc_rdy_n <= 1'b1;
            state          <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
